// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding and default
// time-base / delay widths.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEF_DIV   = 50000;
    localparam int DEF_DIV_W = 32;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/tick_sched_tick_gen.sv
// Divided time base: counts enabled cycles and emits a one-cycle tick every
// DIV+1 of them; clr holds the count at zero.
module tick_gen
    import tick_sched_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_V = DIV_W'(DIV);

    logic [DIV_W-1:0] div_cnt_reg;

    assign tick = en && (div_cnt_reg == DIV_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (clr) begin
            div_cnt_reg <= '0;
        end else if (en) begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Round-robin scheduler granting one requester at a time for a programmable
// number of ticks. Optional abort input enabled by macro TICK_SCHED_ABORT_EN.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DIV   = DEF_DIV,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] delay,
`ifdef TICK_SCHED_ABORT_EN
    input  logic                  abort,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  tick,
    output logic [OW-1:0]         owner
);

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [OW-1:0]    owner_reg, owner_next;
    logic [OW-1:0]    rr_reg, rr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] delay_arr [NREQ];
    logic             found;
    logic [OW-1:0]    winner;
    logic             tick_clr, tick_en, tick_w;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign delay_arr[gi] = delay[gi*CNT_W +: CNT_W];
            assign done[gi]      = (state_reg == FIN) && (owner_reg == OW'(gi));
        end
    endgenerate

    // A zero delay parks in RUN for one cycle without enabling the divider.
    assign tick_clr = (state_reg == IDLE);
    assign tick_en  = (state_reg == RUN) && (count_reg != '0);

    tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick_w)
    );

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(rr_reg) + i) % NREQ]) begin
                found  = 1'b1;
                winner = OW'((int'(rr_reg) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = '0;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    gnt_next[winner] = 1'b1;
                    owner_next       = winner;
                    count_next       = delay_arr[winner];
                    state_next       = RUN;
                end
            end
            RUN: begin
                if (count_reg == '0) begin
                    state_next = FIN;
                end else if (tick_w) begin
                    if (count_reg == CNT_W'(1)) begin
                        state_next = FIN;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
`ifdef TICK_SCHED_ABORT_EN
                if (abort) begin
                    state_next = FIN;
                end
`endif
            end
            FIN: begin
                rr_next    = (owner_reg == OW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            owner_reg <= '0;
            rr_reg    <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            count_reg <= count_next;
        end
    end

    assign gnt   = gnt_reg;
    assign busy  = (state_reg != IDLE);
    assign tick  = tick_w;
    assign owner = owner_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level timing model of the scheduler.
module tb_tick_scheduler;

    localparam int NREQ   = 4;
    localparam int TB_DIV = 3;
    localparam int CNT_W  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] delay = '0;
    logic [NREQ-1:0]       gnt, done;
    logic                  busy, tick;
    logic [1:0]            owner;

    logic [1:0]            big_req = '0;
    logic [2*CNT_W-1:0]    big_delay = '0;
    logic [1:0]            big_gnt, big_done;
    logic                  big_busy, big_tick;
    logic                  big_owner;
`ifdef TICK_SCHED_ABORT_EN
    logic                  abort = 1'b0;
    logic                  big_abort = 1'b0;
`endif

    tick_scheduler #(.NREQ(NREQ), .DIV(TB_DIV), .DIV_W(32), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .delay (delay),
`ifdef TICK_SCHED_ABORT_EN
        .abort (abort),
`endif
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .tick  (tick),
        .owner (owner)
    );

    tick_scheduler #(.NREQ(2), .DIV(0), .DIV_W(32), .CNT_W(CNT_W)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (big_req),
        .delay (big_delay),
`ifdef TICK_SCHED_ABORT_EN
        .abort (big_abort),
`endif
        .gnt   (big_gnt),
        .done  (big_done),
        .busy  (big_busy),
        .tick  (big_tick),
        .owner (big_owner)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, timing from closed-form rules.
    int   m_g = -100, m_e = -100, m_delay = 0, m_owner = 0, m_rr = 0;
    bit   m_valid = 1'b0;
    logic busy_prev = 1'b0;
    int   tick_q[$];
    int   gnt_q[$];
    int   last_done_cyc = -1;

    always @(negedge clk) begin : monitor
        int n, w;
        logic [NREQ-1:0] eg, ed;
        logic et, eb;
        n = cyc;
        if (!rst_n) begin
            check("rst_gnt", gnt, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_tick", tick, 0);
            check("rst_owner", owner, 0);
            m_valid = 1'b0; m_rr = 0; m_owner = 0; m_e = -100; m_g = -100;
            busy_prev = 1'b0;
        end else begin
            eg = '0;
            if (n >= m_e + 2 && req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
                m_owner = w;
                m_g     = n;
                m_delay = int'(delay[w*CNT_W +: CNT_W]);
                m_e     = (m_delay == 0) ? n + 1 : n + m_delay * (TB_DIV + 1);
                m_valid = 1'b1;
                eg[w]   = 1'b1;
            end
            eb = m_valid && n >= m_g && n <= m_e;
            ed = '0;
            if (m_valid && n == m_e) begin
                ed[m_owner] = 1'b1;
                m_rr = (m_owner + 1) % NREQ;
            end
            et = eb && m_delay > 0 && n < m_e && ((n - m_g + 1) % (TB_DIV + 1) == 0);
            check("gnt", gnt, eg);
            check("done", done, ed);
            check("tick", tick, et);
            check("busy", busy, eb);
            check("owner", owner, m_owner);
            if (gnt != '0) begin
                check("gnt_overlap", busy_prev, 0);
                for (int k = 0; k < NREQ; k++) if (gnt[k]) gnt_q.push_back(k);
                tick_q.delete();
            end
            if (tick) tick_q.push_back(n);
            if (done != '0) last_done_cyc = n;
`ifdef TICK_SCHED_ABORT_EN
            if (abort && eb && n < m_e) m_e = n + 1;
`endif
            busy_prev = busy;
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        step;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_gnt", gnt, 0);
        check("async_rst_done", done, 0);
        check("async_rst_owner", owner, 0);
        check("async_rst_big_busy", big_busy, 0);
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, input int idx, input int maxc, output int g);
        g = -1;
        for (int i = 0; i < maxc && g < 0; i++) begin
            step;
            if (gnt[idx]) g = cyc;
        end
        if (g < 0) check({tag, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag, input int maxc, output int c);
        c = -1;
        for (int i = 0; i < maxc && c < 0; i++) begin
            step;
            if (!busy) c = cyc;
        end
        if (c < 0) check({tag, "_idle_timeout"}, 0, 1);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int g, c, ld, tk, tc;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        // Full round of four requesters, delay 1 each
        do_reset;
        gnt_q.delete();
        for (int i = 0; i < NREQ; i++) delay[i*CNT_W +: CNT_W] = 16'd1;
        req = 4'hF;
        for (int i = 0; i < 100 && gnt_q.size() < 5; i++) step;
        req = '0;
        if (gnt_q.size() < 5) check("rr_timeout", gnt_q.size(), 5);
        else for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), gnt_q[i], exp_order[i]);
        wait_idle("rr", 50, c);

        // Single request, delay 2
        do_reset;
        step;
        delay[1*CNT_W +: CNT_W] = 16'd2;
        req[1] = 1'b1;
        wait_gnt("d2", 1, 10, g);
        req = '0;
        wait_idle("d2", 30, c);
        check("d2_done_lat", last_done_cyc - g, 8);
        check("d2_idle_lat", c - g, 9);
        check("d2_ntick", tick_q.size(), 2);
        if (tick_q.size() == 2) begin
            check("d2_tick0", tick_q[0] - g, 3);
            check("d2_tick1", tick_q[1] - g, 7);
        end

        // Zero delay
        step;
        delay[2*CNT_W +: CNT_W] = 16'd0;
        req[2] = 1'b1;
        wait_gnt("d0", 2, 10, g);
        req = '0;
        wait_idle("d0", 10, c);
        check("d0_done_lat", last_done_cyc - g, 1);
        check("d0_ntick", tick_q.size(), 0);

        // Reset in the middle of a count-5 run
        step;
        delay[2*CNT_W +: CNT_W] = 16'd5;
        req[2] = 1'b1;
        wait_gnt("mid", 2, 10, g);
        req = 4'b1110;
        step;
        ld = last_done_cyc;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_owner", owner, 0);
        step;
        step;
        gnt_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 10 && gnt_q.size() == 0; i++) step;
        check("mid_no_done", last_done_cyc, ld);
        if (gnt_q.size() == 0) check("mid_regrant_timeout", 0, 1);
        else check("mid_regrant_idx", gnt_q[0], 1);
        req = '0;
        wait_idle("mid", 100, c);

`ifdef TICK_SCHED_ABORT_EN
        // Abort on the second tick of a delay-10 request
        step;
        delay[0*CNT_W +: CNT_W] = 16'd10;
        req[0] = 1'b1;
        wait_gnt("abort", 0, 10, g);
        req = '0;
        tk = 0;
        tc = -1;
        for (int i = 0; i < 40 && tc < 0; i++) begin
            step;
            if (tick) tk++;
            if (tk == 2) begin
                abort = 1'b1;
                tc = cyc;
            end
        end
        if (tc < 0) check("abort_tick_timeout", 0, 1);
        step;
        abort = 1'b0;
        check("abort_done_cyc", last_done_cyc, tc + 1);
        step;
        check("abort_idle", busy, 0);
`endif

        // Randomized traffic
        for (int s = 0; s < 1500; s++) begin
            step;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    delay[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
                    req[i] = 1'b1;
                end
            end
`ifdef TICK_SCHED_ABORT_EN
            abort = ($urandom_range(0, 15) == 0);
`endif
        end
        req = '0;
`ifdef TICK_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        wait_idle("rand", 200, c);

        // Maximum delay with a tick every cycle
        step;
        big_delay[CNT_W-1:0] = 16'hFFFF;
        big_req[0] = 1'b1;
        g = -1;
        for (int i = 0; i < 10 && g < 0; i++) begin
            step;
            if (big_gnt[0]) g = cyc;
        end
        if (g < 0) check("big_gnt_timeout", 0, 1);
        big_req = '0;
        tk = (big_tick) ? 1 : 0;
        c = -1;
        for (int i = 0; i < 70000 && c < 0; i++) begin
            step;
            if (big_done != '0) begin
                c = cyc;
                check("big_done_vec", big_done, 2'b01);
            end
            if (big_tick) tk++;
        end
        if (c < 0) check("big_done_timeout", 0, 1);
        else check("big_done_lat", c - g, 65535);
        check("big_ntick", tk, 65535);
        step;
        check("big_idle", big_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
